// File: rtl/debounce_sync.sv
// debounce_sync: synchronizes a raw asynchronous input into clk and filters
// out bounces. dout changes only after the synchronized input has held a new
// value for DEBOUNCE_CYCLES consecutive cycles. glitch_cnt counts aborted
// transitions and saturates at its maximum value.
module debounce_sync #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                din_raw,
    output logic                dout,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;
    localparam bit                  MIN_DEB    = (DEBOUNCE_CYCLES == 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   mismatch;
    logic                   dout_q, dout_d;
    logic                   busy_q, busy_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [GLITCH_W-1:0]    glitch_q, glitch_d;

    // Synchronizer chain: plain shift of flops, nothing between stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_raw};
        end
    end

    assign s        = sync_q[SYNC_STAGES-1];
    assign mismatch = (s != dout_q);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_STABLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: enter PENDING on a new level, leave on accept or glitch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STABLE: begin
                if (mismatch && !MIN_DEB) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (!mismatch || (cnt_q == CNT_LAST)) begin
                    state_d = ST_STABLE;
                end
            end
            default: state_d = ST_STABLE;
        endcase
    end

    // Output/datapath next values: counter, accepted level, glitch counter.
    always_comb begin
        dout_d   = dout_q;
        cnt_d    = cnt_q;
        glitch_d = glitch_q;
        busy_d   = (state_d == ST_PENDING);
        case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (mismatch) begin
                    if (MIN_DEB) begin
                        dout_d = s;
                    end else begin
                        cnt_d = CNT_W'(1);
                    end
                end
            end
            ST_PENDING: begin
                if (mismatch) begin
                    if (cnt_q == CNT_LAST) begin
                        dout_d = s;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    // Input fell back before the hold time: reject and count it.
                    cnt_d = '0;
                    if (glitch_q != GLITCH_MAX) begin
                        glitch_d = glitch_q + GLITCH_W'(1);
                    end
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Registered outputs and counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q   <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            glitch_q <= '0;
        end else begin
            dout_q   <= dout_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            glitch_q <= glitch_d;
        end
    end

    assign dout       = dout_q;
    assign busy       = busy_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboarded bench for debounce_sync: three parameterisations driven by the
// same stimulus, each checked against a run-length reference model.
module tb_debounce_sync;

    localparam int SYNCP [3] = '{2, 3, 2};
    localparam int DEBP  [3] = '{4, 4, 1};
    localparam int GWP   [3] = '{8, 2, 8};

    typedef struct packed {
        logic       d;
        logic       b;
        logic [7:0] g;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       din_raw;
    logic       dout0, busy0, dout1, busy1, dout2, busy2;
    logic [7:0] gc0, gc2;
    logic [1:0] gc1;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   rises_m   = 0;
    int   rises_dut = 0;
    exp_t q0[$], q1[$], q2[$];

    bit [3:0] hist [3];
    bit       m_dout [3];
    int       m_run  [3];
    int       m_gc   [3];

    always #5 clk = ~clk;

    debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .GLITCH_W(8)) u_dut0 (
        .clk(clk), .reset(reset), .din_raw(din_raw),
        .dout(dout0), .busy(busy0), .glitch_cnt(gc0));
    debounce_sync #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(4), .GLITCH_W(2)) u_dut1 (
        .clk(clk), .reset(reset), .din_raw(din_raw),
        .dout(dout1), .busy(busy1), .glitch_cnt(gc1));
    debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .GLITCH_W(8)) u_dut2 (
        .clk(clk), .reset(reset), .din_raw(din_raw),
        .dout(dout2), .busy(busy2), .glitch_cnt(gc2));

    // Reference: dout flips once the delayed input has disagreed for DEB edges in a row.
    task automatic model_step(input bit r, input bit d);
        bit   s;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                hist[i] = '0; m_dout[i] = 0; m_run[i] = 0; m_gc[i] = 0;
            end else begin
                s = hist[i][SYNCP[i]-1];
                hist[i] = {hist[i][2:0], d};
                if (s != m_dout[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEBP[i]) begin
                        m_dout[i] = s;
                        m_run[i]  = 0;
                        if (i == 0 && s) rises_m++;
                    end
                end else begin
                    if (m_run[i] > 0 && m_gc[i] < (1 << GWP[i]) - 1) m_gc[i]++;
                    m_run[i] = 0;
                end
            end
            e.d = m_dout[i];
            e.b = (m_run[i] != 0);
            e.g = 8'(m_gc[i]);
            case (i)
                0: q0.push_back(e);
                1: q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    task automatic drive(input bit r, input bit d);
        reset   = r;
        din_raw = d;
        model_step(r, d);
        @(negedge clk);
    endtask

    task automatic hold(input bit d, input int n);
        for (int k = 0; k < n; k++) drive(1'b0, d);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pop one expectation per instance after every active edge.
    initial begin
        exp_t e;
        logic prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("dout0", 8'(dout0), 8'(e.d));
                check("busy0", 8'(busy0), 8'(e.b));
                check("glitch0", gc0, e.g);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("dout1", 8'(dout1), 8'(e.d));
                check("busy1", 8'(busy1), 8'(e.b));
                check("glitch1", 8'(gc1), e.g);
            end
            if (q2.size() > 0) begin
                e = q2.pop_front();
                check("dout2", 8'(dout2), 8'(e.d));
                check("busy2", 8'(busy2), 8'(e.b));
                check("glitch2", gc2, e.g);
            end
            if (dout0 === 1'b1 && prev === 1'b0) rises_dut++;
            prev = dout0;
        end
    end

    initial begin
        int len;
        bit v;
        // Reset, then clean rise and fall.
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0);
        hold(1'b1, 10);
        hold(1'b0, 10);
        // Bounce: 1x2, 0x1, 1x3, 0x1, then steady high.
        hold(1'b1, 2); hold(1'b0, 1); hold(1'b1, 3); hold(1'b0, 1);
        hold(1'b1, 12);
        hold(1'b0, 12);
        // Five isolated one-cycle pulses (saturation on the 2-bit instance).
        for (int p = 0; p < 5; p++) begin
            hold(1'b1, 1);
            hold(1'b0, 9);
        end
        // Reset in the middle of a pending rise.
        hold(1'b1, 3);
        drive(1'b1, 1'b1);
        hold(1'b1, 10);
        hold(1'b0, 12);
        // Toggle every 3 cycles (tracks directly on the DEB=1 instance).
        for (int t = 0; t < 8; t++) hold(t[0] ? 1'b0 : 1'b1, 3);
        hold(1'b0, 10);
        // Ten bounced presses with three glitches each.
        for (int p = 0; p < 10; p++) begin
            hold(1'b1, 1); hold(1'b0, 1);
            hold(1'b1, 1); hold(1'b0, 1);
            hold(1'b1, 1); hold(1'b0, 1);
            hold(1'b1, 8);
            hold(1'b0, 8);
        end
        // Randomized segments with occasional resets.
        for (int k = 0; k < 150; k++) begin
            len = $urandom_range(1, 7);
            v   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) drive(1'b1, v);
            hold(v, len);
        end
        hold(1'b0, 12);
        for (int k = 0; k < 20 && (q0.size() + q1.size() + q2.size()) > 0; k++) @(posedge clk);
        #2;
        checks++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", q0.size() + q1.size() + q2.size());
        end
        check("rise_count", 8'(rises_dut), 8'(rises_m));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_sync.md
# debounce_sync

Input conditioner that sits directly upstream of the rising-edge pulse detector. It takes a raw, asynchronous, possibly bouncing input, synchronizes it into `clk`, and filters it. It drives a clean level, `dout`, that changes only after the synchronized input has held a new value for a programmable number of consecutive cycles. `dout` connects straight to the edge detector's `din`. The block also reports how many aborted (glitch) transitions it has rejected.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops; legal range 2–4.
- `DEBOUNCE_CYCLES`, default 4: consecutive mismatching samples required before `dout` changes; legal range 1–65535.
- `GLITCH_W`, default 8: width of the glitch counter.
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: **synchronous, active-high reset**; sampled on the rising edge of `clk`.
- `din_raw`, in, 1: asynchronous raw input; may bounce.
- `dout`, out, 1: debounced, synchronized level; registered.
- `busy`, out, 1: high while a candidate transition is pending (PENDING state); registered.
- `glitch_cnt`, out, `GLITCH_W`: saturating count of rejected transitions; registered.

## Operation
- **Synchronizer:** a chain of `SYNC_STAGES` flops samples `din_raw`. `s` is the output of the last flop. No logic is placed between synchronizer flops.
- **Counter:** `cnt` is wide enough to hold `DEBOUNCE_CYCLES-1` (clog2, minimum 1 bit).
- **FSM states:** STABLE and PENDING. `dout` holds the accepted level in both states.
- **STABLE:**
  - If `s == dout`: stay in STABLE with `cnt = 0`.
  - If `s != dout` and `DEBOUNCE_CYCLES == 1`: `dout <= s` immediately; stay in STABLE.
  - If `s != dout` otherwise: go to PENDING with `cnt <= 1`.
- **PENDING:**
  - If `s != dout` and `cnt == DEBOUNCE_CYCLES-1`: `dout <= s`, `cnt <= 0`, go to STABLE.
  - If `s != dout` otherwise: `cnt <= cnt+1`.
  - If `s == dout`: this is a glitch. `cnt <= 0`, go to STABLE, and `glitch_cnt <= glitch_cnt+1` unless it is already all-ones (saturates, never wraps).
- `busy` is 1 exactly when the FSM is in PENDING.
- **Edge behaviour downstream:** `dout` toggles at most once per `DEBOUNCE_CYCLES` cycles, so the edge detector sees at most one rising edge per accepted low-to-high transition.
- **Reset:**
  - Synchronizer flops, `dout`, `cnt`, `busy` and `glitch_cnt` all go to 0; FSM goes to STABLE.
  - Reset has priority over every other update.
  - A reset applied mid-PENDING discards the pending transition and does not count a glitch.
- **Input high across reset:** if `din_raw` is 1 during and after reset, the full latency applies from the first post-reset edge. `dout` rises once, and the downstream detector produces one pulse.

## Timing
- **Latency:** with `din_raw` stable at a new value from edge E0 (the first edge that samples it), `dout` changes on edge E(`SYNC_STAGES+DEBOUNCE_CYCLES-1`).
  - Defaults: `dout` updates on the 6th edge (E5).
- **Busy window:** `busy` rises on edge E(`SYNC_STAGES`) and falls on the same edge on which `dout` updates.
- **Glitch rejection:** a `din_raw` pulse shorter than `DEBOUNCE_CYCLES` cycles (after synchronization) never changes `dout`, and adds 1 to `glitch_cnt`.
- **Glitch counter update:** `glitch_cnt` updates on the edge on which PENDING returns to STABLE without a flip.
- **Reset timing:** outputs read 0 on the first edge at which `reset` is sampled high and stay 0 while it is held. Normal operation resumes on the first edge with `reset` low.
- **Metastability:** only the first synchronizer flop may go metastable. The block makes no claim on which edge a transition arriving near an edge is first captured (±1 cycle).

## Test plan
- **Clean rise and fall:** reset 3 cycles, then `din_raw` = 1 from E0 (defaults).
  - Required: `dout` = 1 after E5, `busy` high after E2 to E4, `glitch_cnt` stays 0.
  - Then `din_raw` = 0: `dout` = 0 exactly 6 edges later.
- **Bounce:** `din_raw` = 1 for 2 cycles, 0 for 1, 1 for 3, 0 for 1, then 1 steady.
  - Required: `dout` rises exactly once, 6 edges after the final 0→1 sample, and `glitch_cnt` = 2.
- **Saturation:** with `GLITCH_W` = 2, inject 5 isolated 1-cycle pulses.
  - Required: `glitch_cnt` sequence 1, 2, 3, 3, 3; `dout` stays 0 throughout.
- **Reset mid-PENDING:** `din_raw` = 1; assert `reset` for 1 cycle at E3; hold `din_raw` = 1.
  - Required: `dout` = 0 and `busy` = 0 after E3, `glitch_cnt` = 0, and `dout` = 1 six edges after E4.
- **Minimum debounce:** `DEBOUNCE_CYCLES` = 1, `SYNC_STAGES` = 2, `din_raw` toggled every 3 cycles.
  - Required: `dout` follows `din_raw` delayed by 2 edges, `busy` never asserts, `glitch_cnt` stays 0.
- **Chained with edge detector:** 10 bounced presses (each with 3 glitches), fed through this block into the edge detector.
  - Required: exactly 10 one-cycle output pulses and `glitch_cnt` = 30.
